// File: rtl/gpio_axil_slave.sv
// AXI4-Lite GPIO slave: DATA/TRI registers plus atomic SET/CLR views of the output register,
// with a multi-stage synchroniser on the GPIO input pins.
module gpio_axil_slave #(
   parameter int          WIDTH       = 32,
   parameter int          ADDR_W      = 4,
   parameter logic [31:0] RESET_O     = 32'h0000_0000,
   parameter logic [31:0] RESET_T     = 32'hFFFF_FFFF,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [WIDTH-1:0]      s_axi_wdata,
   input  logic [WIDTH/8-1:0]    s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [WIDTH-1:0]      s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [WIDTH-1:0]      gpio_o,
   output logic [WIDTH-1:0]      gpio_t,
   input  logic [WIDTH-1:0]      gpio_i
);

   function automatic logic [WIDTH-1:0] strb_mask(input logic [WIDTH/8-1:0] strb);
      strb_mask = {WIDTH{1'b0}};
      for (int n = 0; n < WIDTH/8; n++) begin
         strb_mask[8*n +: 8] = {8{strb[n]}};
      end
   endfunction

   logic [WIDTH-1:0]                  r_o;
   logic [WIDTH-1:0]                  r_t;
   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic                              r_bvalid;
   logic [1:0]                        r_bresp;
   logic                              r_rvalid;
   logic [1:0]                        r_rresp;
   logic [WIDTH-1:0]                  r_rdata;

   logic             w_wr_acc;
   logic             w_rd_acc;
   logic             w_aw_err;
   logic             w_ar_err;
   logic [WIDTH-1:0] w_bits;
   logic [WIDTH-1:0] w_o_nxt;
   logic [WIDTH-1:0] w_t_nxt;
   logic [WIDTH-1:0] w_rdata_nxt;
   logic             w_unused;

   assign w_wr_acc = s_axi_awvalid & s_axi_wvalid & ~r_bvalid;
   assign w_rd_acc = s_axi_arvalid & ~r_rvalid;
   // Bits above the 16-byte window only exist when ADDR_W > 4; they flag an unmapped access.
   assign w_aw_err = (s_axi_awaddr >> 3'd4) != {ADDR_W{1'b0}};
   assign w_ar_err = (s_axi_araddr >> 3'd4) != {ADDR_W{1'b0}};
   assign w_bits   = s_axi_wdata & strb_mask(s_axi_wstrb);
   assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   // Next values of the output and tri-state registers for an accepted write.
   always_comb begin
      w_o_nxt = r_o;
      w_t_nxt = r_t;
      if (w_wr_acc && !w_aw_err) begin
         case (s_axi_awaddr[3:2])
            2'd0:    w_o_nxt = (r_o & ~strb_mask(s_axi_wstrb)) | w_bits;
            2'd1:    w_t_nxt = (r_t & ~strb_mask(s_axi_wstrb)) | w_bits;
            2'd2:    w_o_nxt = r_o | w_bits;
            2'd3:    w_o_nxt = r_o & ~w_bits;
            default: w_o_nxt = r_o;
         endcase
      end else begin
         w_o_nxt = r_o;
         w_t_nxt = r_t;
      end
   end

   // Read mux; sees pre-write register values when a write lands on the same edge.
   always_comb begin
      w_rdata_nxt = {WIDTH{1'b0}};
      if (w_ar_err) begin
         w_rdata_nxt = {WIDTH{1'b0}};
      end else begin
         case (s_axi_araddr[3:2])
            2'd0:    w_rdata_nxt = r_sync[SYNC_STAGES-1];
            2'd1:    w_rdata_nxt = r_t;
            default: w_rdata_nxt = {WIDTH{1'b0}};
         endcase
      end
   end

   // GPIO registers and input synchroniser.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_o    <= RESET_O[WIDTH-1:0];
         r_t    <= RESET_T[WIDTH-1:0];
         r_sync <= {(SYNC_STAGES*WIDTH){1'b0}};
      end else begin
         r_o    <= w_o_nxt;
         r_t    <= w_t_nxt;
         r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_i};
      end
   end

   // Write response channel.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_bvalid <= 1'b0;
         r_bresp  <= 2'b00;
      end else if (w_wr_acc) begin
         r_bvalid <= 1'b1;
         r_bresp  <= w_aw_err ? 2'b10 : 2'b00;
      end else if (r_bvalid && s_axi_bready) begin
         r_bvalid <= 1'b0;
      end else begin
         r_bvalid <= r_bvalid;
      end
   end

   // Read data channel; rdata/rresp held until the handshake.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rvalid <= 1'b0;
         r_rresp  <= 2'b00;
         r_rdata  <= {WIDTH{1'b0}};
      end else if (w_rd_acc) begin
         r_rvalid <= 1'b1;
         r_rresp  <= w_ar_err ? 2'b10 : 2'b00;
         r_rdata  <= w_rdata_nxt;
      end else if (r_rvalid && s_axi_rready) begin
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= r_rvalid;
      end
   end

   assign s_axi_awready = w_wr_acc;
   assign s_axi_wready  = w_wr_acc;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bresp   = r_bresp;
   assign s_axi_arready = ~r_rvalid;
   assign s_axi_rvalid  = r_rvalid;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;
   assign gpio_o        = r_o;
   assign gpio_t        = r_t;

endmodule

// File: tb/tb_gpio_axil_slave.sv
// Self-checking bench for gpio_axil_slave: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a byte-level register model.
module tb_gpio_axil_slave;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic [3:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [3:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic [31:0] gpio_o;
   logic [31:0] gpio_t;
   logic [31:0] gpio_i;

   gpio_axil_slave dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .gpio_o(gpio_o), .gpio_t(gpio_t), .gpio_i(gpio_i)
   );

   always #5 ap_clk = ~ap_clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_o;
   logic [31:0] m_t;
   logic [31:0] m_pins;

   typedef struct {
      bit          wr;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_o;
      logic [31:0] exp_t;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Register model: applies a write byte by byte from the register map rules.
   task automatic model_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) begin
            case (a[3:2])
               2'd0:    m_o[8*b +: 8] = d[8*b +: 8];
               2'd1:    m_t[8*b +: 8] = d[8*b +: 8];
               2'd2:    m_o[8*b +: 8] = m_o[8*b +: 8] | d[8*b +: 8];
               default: m_o[8*b +: 8] = m_o[8*b +: 8] & ~d[8*b +: 8];
            endcase
         end
      end
   endtask

   function automatic logic [31:0] model_read(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return m_pins;
         2'd1:    return m_t;
         default: return 32'h0;
      endcase
   endfunction

   task automatic do_reset();
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      repeat (3) @(posedge ap_clk);
      m_o = 32'h0000_0000;
      m_t = 32'hFFFF_FFFF;
   endtask

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      @(negedge ap_clk);
      s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      #1;
      n = 0;
      while (!s_axi_awready && n < 20) begin
         @(negedge ap_clk); #1; n++;
      end
      chk("wr_awready", 32'(s_axi_awready), 32'd1);
      chk("wr_wready", 32'(s_axi_wready), 32'd1);
      @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      chk("wr_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("wr_bresp", 32'(s_axi_bresp), 32'd0);
      s_axi_bready = 1'b1;
      @(negedge ap_clk);
      s_axi_bready = 1'b0;
      chk("wr_bvalid_clr", 32'(s_axi_bvalid), 32'd0);
   endtask

   task automatic axi_read(input logic [3:0] a, input logic [31:0] exp_d);
      @(negedge ap_clk);
      s_axi_araddr = a; s_axi_arvalid = 1'b1;
      #1;
      chk("rd_arready", 32'(s_axi_arready), 32'd1);
      @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_arvalid = 1'b0;
      chk("rd_rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("rd_rdata", s_axi_rdata, exp_d);
      chk("rd_rresp", 32'(s_axi_rresp), 32'd0);
      s_axi_rready = 1'b1;
      @(negedge ap_clk);
      s_axi_rready = 1'b0;
      chk("rd_rvalid_clr", 32'(s_axi_rvalid), 32'd0);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 4'h0, 32'h0007_0000, 4'hF, 32'h0007_0000, 32'hFFFF_FFFF, 32'h0};
      tbl[1]  = '{1'b1, 4'h8, 32'h0100_0000, 4'hF, 32'h0107_0000, 32'hFFFF_FFFF, 32'h0};
      tbl[2]  = '{1'b1, 4'hC, 32'h0001_0000, 4'hF, 32'h0106_0000, 32'hFFFF_FFFF, 32'h0};
      tbl[3]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0,         32'h0,         32'h0};
      tbl[4]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0,         32'h0,         32'h0};
      tbl[5]  = '{1'b1, 4'h4, 32'h1234_5678, 4'h5, 32'h0106_0000, 32'hFF34_FF78, 32'h0};
      tbl[6]  = '{1'b0, 4'h5, 32'h0,         4'h0, 32'h0,         32'h0,         32'hFF34_FF78};
      tbl[7]  = '{1'b1, 4'h0, 32'hAABB_CCDD, 4'h0, 32'h0106_0000, 32'hFF34_FF78, 32'h0};
      tbl[8]  = '{1'b1, 4'h8, 32'hFFFF_FFFF, 4'h2, 32'h0106_FF00, 32'hFF34_FF78, 32'h0};
      tbl[9]  = '{1'b1, 4'hC, 32'hFFFF_FFFF, 4'h8, 32'h0006_FF00, 32'hFF34_FF78, 32'h0};
      tbl[10] = '{1'b1, 4'h0, 32'h1122_3344, 4'h3, 32'h0006_3344, 32'hFF34_FF78, 32'h0};
      tbl[11] = '{1'b0, 4'h3, 32'h0,         4'h0, 32'h0,         32'h0,         32'hCAFE_F00D};
      tbl[12] = '{1'b1, 4'h4, 32'h0000_0000, 4'hF, 32'h0006_3344, 32'h0000_0000, 32'h0};
      tbl[13] = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0,         32'h0,         32'h0};

      s_axi_awaddr = 4'h0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
      s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = 4'h0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0; gpio_i = 32'hCAFE_F00D; m_pins = 32'hCAFE_F00D;
      ap_rst_n = 1'b0;
      do_reset();

      // Reset state with no traffic
      @(negedge ap_clk);
      chk("rst_gpio_o", gpio_o, 32'h0000_0000);
      chk("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
      chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
      chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("rst_awready", 32'(s_axi_awready), 32'd0);
      chk("rst_arready", 32'(s_axi_arready), 32'd1);
      chk("rst_rdata", s_axi_rdata, 32'h0);

      for (int i = 0; i < 14; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            chk($sformatf("tbl%0d_gpio_o", i), gpio_o, tbl[i].exp_o);
            chk($sformatf("tbl%0d_gpio_t", i), gpio_t, tbl[i].exp_t);
         end else begin
            axi_read(tbl[i].addr, tbl[i].exp_rd);
         end
      end

      do_reset();

      // Pin change visible after two edges; read held with rready low
      @(negedge ap_clk);
      gpio_i = 32'h0000_0C00;
      @(posedge ap_clk); @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_araddr = 4'h4; gpio_i = 32'h0;
      for (int k = 0; k < 5; k++) begin
         chk("hold_rvalid", 32'(s_axi_rvalid), 32'd1);
         chk("hold_rdata", s_axi_rdata, 32'h0000_0C00);
         chk("hold_rresp", 32'(s_axi_rresp), 32'd0);
         chk("hold_arready", 32'(s_axi_arready), 32'd0);
         @(negedge ap_clk);
      end
      s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
      @(negedge ap_clk);
      s_axi_rready = 1'b0;
      chk("hold_rvalid_clr", 32'(s_axi_rvalid), 32'd0);

      // Write response stalled by bready; second write waits
      @(negedge ap_clk);
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'h5;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_awaddr = 4'h0; s_axi_wdata = 32'h0000_00AA; s_axi_wstrb = 4'hF;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_bvalid", 32'(s_axi_bvalid), 32'd1);
         chk("stall_awready", 32'(s_axi_awready), 32'd0);
         chk("stall_gpio_t", gpio_t, 32'hFF34_FF78);
         chk("stall_gpio_o", gpio_o, 32'h0);
         @(negedge ap_clk);
      end
      s_axi_bready = 1'b1;
      @(negedge ap_clk);
      s_axi_bready = 1'b0;
      #1;
      chk("resume_awready", 32'(s_axi_awready), 32'd1);
      @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      chk("resume_bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("resume_gpio_o", gpio_o, 32'h0000_00AA);
      s_axi_bready = 1'b1;
      @(negedge ap_clk);
      s_axi_bready = 1'b0;

      // Simultaneous read and write on the same edge, then reset with responses pending
      gpio_i = 32'h5A5A_0000;
      repeat (3) @(negedge ap_clk);
      s_axi_awaddr = 4'h4; s_axi_wdata = 32'h0; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      chk("sim_tri_rdata", s_axi_rdata, 32'hFF34_FF78);
      chk("sim_tri_gpio_t", gpio_t, 32'h0);
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      @(negedge ap_clk);
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      s_axi_awaddr = 4'h0; s_axi_wdata = 32'h0000_00FF; s_axi_wstrb = 4'hF;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      chk("sim_data_rdata", s_axi_rdata, 32'h5A5A_0000);
      chk("sim_data_gpio_o", gpio_o, 32'h0000_00FF);
      chk("sim_bvalid", 32'(s_axi_bvalid), 32'd1);
      ap_rst_n = 1'b0;
      #1;
      chk("arst_bvalid", 32'(s_axi_bvalid), 32'd0);
      chk("arst_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("arst_gpio_o", gpio_o, 32'h0);
      chk("arst_gpio_t", gpio_t, 32'hFFFF_FFFF);

      // Randomized traffic against the model
      m_pins = 32'h5A5A_0000;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         int op;
         logic [3:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         op = int'($urandom_range(0, 2));
         a  = 4'($urandom);
         d  = $urandom;
         s  = 4'($urandom);
         if (op == 0) begin
            axi_write(a, d, s);
            model_write(a, d, s);
            chk("rnd_gpio_o", gpio_o, m_o);
            chk("rnd_gpio_t", gpio_t, m_t);
         end else if (op == 1) begin
            axi_read(a, model_read(a));
         end else begin
            @(negedge ap_clk);
            m_pins = $urandom;
            gpio_i = m_pins;
            @(posedge ap_clk); @(posedge ap_clk);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
